// File: rtl/regdump_pkg.sv
// Shared types and default sizing for the register-file dump engine.
package regdump_pkg;

  localparam int unsigned NUM_REGS_DEF = 32;
  localparam int unsigned ADDR_W_DEF   = 5;
  localparam int unsigned DATA_W_DEF   = 32;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPT,
    VALID,
    DONE
  } state_e;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Valid/ready beat stream from the dump engine to a trace or debug sink.
interface regfile_dump_reader_if
  import regdump_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_index;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_sum;

  modport master (
    output out_valid, out_index, out_data, out_last, out_sum,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_index, out_data, out_last, out_sum,
    output out_ready
  );

endinterface

// File: rtl/regdump_xor_acc.sv
// Running XOR of every register value captured during a dump.
module regdump_xor_acc
  import regdump_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] acc
);

  logic [DATA_W-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr)     acc_d = '0;
    else if (en) acc_d = acc_q ^ din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks every register through read port 1 and streams one beat per register.
// Define REGDUMP_CHECKSUM_EN to append an XOR checksum beat after the last register.
module regfile_dump_reader
  import regdump_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  rf_we,
  output logic [ADDR_W-1:0]     rf_addr,
  input  logic [DATA_W-1:0]     rf_rd,
  regfile_dump_reader_if.master dump,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

`ifdef REGDUMP_CHECKSUM_EN
  localparam bit SUM_EN = 1'b1;
`else
  localparam bit SUM_EN = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic              sum_phase_q, sum_phase_d;
  logic              is_last_reg;
  logic [DATA_W-1:0] acc;

  assign is_last_reg = (idx_q == LAST_IDX);

  // NOTE: every always_comb output is given a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    index_d     = index_q;
    data_d      = data_q;
    last_d      = last_q;
    sum_phase_d = sum_phase_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          idx_d       = '0;
          sum_phase_d = 1'b0;
          state_d     = ISSUE;
        end
      end
      // A CPU write owns RD1 this edge; the checksum beat never touches the register file.
      ISSUE: begin
        if (!rf_we || sum_phase_q) state_d = CAPT;
      end
      CAPT: begin
        state_d = VALID;
        index_d = sum_phase_q ? '0  : idx_q;
        data_d  = sum_phase_q ? acc : rf_rd;
        last_d  = sum_phase_q || (is_last_reg && !SUM_EN);
      end
      VALID: begin
        if (dump.out_ready) begin
          if (last_q) begin
            state_d = DONE;
          end else if (is_last_reg) begin
            sum_phase_d = 1'b1;
            state_d     = ISSUE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ISSUE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      index_q     <= '0;
      data_q      <= '0;
      last_q      <= 1'b0;
      sum_phase_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      index_q     <= index_d;
      data_q      <= data_d;
      last_q      <= last_d;
      sum_phase_q <= sum_phase_d;
    end
  end

`ifdef REGDUMP_CHECKSUM_EN
  regdump_xor_acc #(
    .DATA_W (DATA_W)
  ) u_xor_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   ((state_q == IDLE) && start),
    .en    ((state_q == CAPT) && !sum_phase_q),
    .din   (rf_rd),
    .acc   (acc)
  );
  assign dump.out_sum = sum_phase_q && (state_q == VALID);
`else
  assign acc          = '0;
  assign dump.out_sum = 1'b0;
`endif

  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);
  assign rf_addr        = busy ? idx_q : '0;
  assign dump.out_valid = (state_q == VALID);
  assign dump.out_index = index_q;
  assign dump.out_data  = data_q;
  assign dump.out_last  = last_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Randomised bench for regfile_dump_reader with a beat-level reference model and register-file stand-in.
module tb_regfile_dump_reader;

  localparam int NR = 32;
  localparam int AW = 5;
  localparam int DW = 32;
`ifdef REGDUMP_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int NB = NR + (CHK ? 1 : 0);

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          rf_we = 1'b0;
  logic [AW-1:0] wa    = '0;
  logic [DW-1:0] wd    = '0;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_rd;
  logic          busy, done;

  regfile_dump_reader_if #(.ADDR_W(AW), .DATA_W(DW)) dump_if ();

  regfile_dump_reader #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .rf_we   (rf_we),
    .rf_addr (rf_addr),
    .rf_rd   (rf_rd),
    .dump    (dump_if),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Register file: a write edge leaves RD1 untouched, otherwise RD1 follows A1.
  logic [DW-1:0] rf_mem [NR];
  always @(posedge clk) begin
    if (rf_we) rf_mem[wa] <= wd;
    else       rf_rd      <= rf_mem[rf_addr];
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Beat-level model: which beat is owed, what it must carry, when done is due.
  int            cyc       = 0;
  int            start_cyc = 0;
  int            gen       = 0;
  int            accepted  = 0;
  int            done_rel  = -1;
  bit            dumping   = 1'b0;
  bit            done_exp  = 1'b0;
  bit            pend      = 1'b0;
  logic [DW-1:0] xor_exp   = '0;
  int            first_valid [NB];
  int            first_gen   [NB];
  logic [DW-1:0] cap_data    [NB];

  function automatic logic [AW+DW+1:0] beat_exp(input int b);
    logic [AW-1:0] ix;
    ix = AW'(b);
    if (b < NR) return {ix, rf_mem[b], (b == NR - 1) && !CHK, 1'b0};
    return {AW'(0), xor_exp, 1'b1, 1'b1};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dumping  <= 1'b0;
      done_exp <= 1'b0;
      accepted <= 0;
      pend     <= 1'b0;
      xor_exp  <= '0;
    end else begin
      pend <= dump_if.out_valid && !dump_if.out_ready;
      if (done_exp) begin
        done_exp <= 1'b0;
        dumping  <= 1'b0;
      end else if (dumping && dump_if.out_valid && dump_if.out_ready && accepted < NB) begin
        cap_data[accepted] <= dump_if.out_data;
        if (accepted < NR) xor_exp <= xor_exp ^ rf_mem[accepted];
        if (accepted == NB - 1) done_exp <= 1'b1;
        accepted <= accepted + 1;
      end else if (!dumping && start) begin
        dumping   <= 1'b1;
        accepted  <= 0;
        xor_exp   <= '0;
        start_cyc <= cyc + 1;
        gen       <= gen + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_outputs", {dump_if.out_valid, dump_if.out_index, dump_if.out_data,
                              dump_if.out_last, dump_if.out_sum, busy, done, rf_addr}, '0);
    end else begin
      check("busy", busy, dumping);
      check("done", done, done_exp);
      if (!dumping || done_exp) check("valid_outside_dump", dump_if.out_valid, 1'b0);
      if (pend) check("valid_held", dump_if.out_valid, 1'b1);
      if (!dumping) check("rf_addr_idle", rf_addr, '0);
      else if (!done_exp && accepted < NR) check("rf_addr", rf_addr, accepted);
      if (dumping && dump_if.out_valid && accepted < NB) begin
        check("beat", {dump_if.out_index, dump_if.out_data, dump_if.out_last, dump_if.out_sum},
              beat_exp(accepted));
        if (first_gen[accepted] != gen) begin
          first_gen[accepted]   <= gen;
          first_valid[accepted] <= cyc - start_cyc;
        end
      end
      if (done) begin
        done_rel <= cyc - start_cyc;
        check("beat_count", accepted, NB);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int base);
    for (int i = 0; i < NR; i++) begin
      rf_we = 1'b1;
      wa    = AW'(i);
      wd    = DW'(base + i);
      step();
    end
    rf_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Never writes the register currently being fetched, so its beat value is fixed.
  task automatic random_cycle();
    int j;
    dump_if.out_ready = ($urandom_range(0, 3) != 0);
    start = busy && ($urandom_range(0, 15) == 0);
    rf_we = ($urandom_range(0, 3) == 0);
    j = $urandom_range(0, NR - 1);
    if (j == accepted) j = (j + 1) % NR;
    wa = AW'(j);
    wd = $urandom;
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      if (done) seen = 1'b1;
      else begin
        if (rnd) random_cycle();
        step();
      end
    end
    check("done_seen", seen, 1'b1);
    start             = 1'b0;
    rf_we             = 1'b0;
    dump_if.out_ready = 1'b1;
    step();
  endtask

  initial begin
    dump_if.out_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Plain dump of r_i = 100+i with an always-ready sink.
    preload(100);
    pulse_start();
    wait_done(400, 1'b0);
    check("t1_first_latency", first_valid[0], 2);
    check("t1_last_reg_cycle", first_valid[NR-1], 95);
    check("t1_done_cycles", done_rel + 1, CHK ? 100 : 97);
    check("t1_data0", cap_data[0], 100);
    check("t1_data31", cap_data[NR-1], 131);

    // Four write cycles during ISSUE of register 5.
    pulse_start();
    repeat (15) step();
    rf_we = 1'b1;
    wa    = AW'(20);
    wd    = 32'hCAFE_0014;
    repeat (4) step();
    rf_we = 1'b0;
    wait_done(400, 1'b0);
    check("t2_beat4_cycle", first_valid[4], 14);
    check("t2_beat5_cycle", first_valid[5], 21);
    check("t2_beat6_cycle", first_valid[6], 24);
    check("t2_beat5_data", cap_data[5], 105);
    check("t2_reg20_write", cap_data[20], 32'hCAFE_0014);
    check("t2_done_cycles", done_rel + 1, CHK ? 104 : 101);

    // Random backpressure, CPU writes and stray starts.
    for (int d = 0; d < 4; d++) begin
      pulse_start();
      wait_done(3000, 1'b1);
    end

    // Start during beat 10 is ignored; start after done runs a second dump.
    preload(100);
    pulse_start();
    repeat (32) step();
    check("t4_beat10_valid", {dump_if.out_valid, dump_if.out_index}, {1'b1, 5'd10});
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(400, 1'b0);
    check("t4_done_cycles", done_rel + 1, CHK ? 100 : 97);
    repeat (5) step();
    check("t4_still_idle", busy, 1'b0);
    pulse_start();
    wait_done(400, 1'b0);
    check("t4_second_done_cycles", done_rel + 1, CHK ? 100 : 97);
    check("t4_second_data31", cap_data[NR-1], 131);

    // Reset while beat 7 is presented.
    pulse_start();
    repeat (23) step();
    check("t5_beat7_valid", {dump_if.out_valid, dump_if.out_index}, {1'b1, 5'd7});
    rst_n = 1'b0;
    #1;
    check("t5_reset_valid", dump_if.out_valid, 1'b0);
    check("t5_reset_busy", busy, 1'b0);
    check("t5_reset_beat", {dump_if.out_index, dump_if.out_data, dump_if.out_last, dump_if.out_sum}, '0);
    check("t5_reset_rf_addr", rf_addr, '0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    pulse_start();
    wait_done(400, 1'b0);
    check("t5_restart_latency", first_valid[0], 2);
    check("t5_restart_data0", cap_data[0], 100);

`ifdef REGDUMP_CHECKSUM_EN
    // r_i = i: XOR of 0..31 is zero.
    preload(0);
    pulse_start();
    wait_done(400, 1'b0);
    check("t6_sum_data", cap_data[NR], 0);
    check("t6_data31", cap_data[NR-1], 31);
    check("t6_sum_cycle", first_valid[NR], 98);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
